// File: rtl/arch_rat_retire_pkg.sv
// Shared definitions for the architectural register alias table: default sizes,
// recovery FSM encoding and a beat-index width helper.
package arch_rat_retire_pkg;

    localparam int unsigned ARCH_REGS_DEF   = 32;
    localparam int unsigned PREG_W_DEF      = 7;
    localparam int unsigned RETIRE_W_DEF    = 4;
    localparam int unsigned RECOV_LANES_DEF = 8;
    localparam int unsigned AR_W_DEF        = $clog2(ARCH_REGS_DEF);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StCopy = 1'b1
    } rat_state_e;

    // Beat index needs at least one bit even when the map fits in one beat.
    function automatic int unsigned idx_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/arch_rat_retire_if.sv
// Retire / free-list / recovery-stream bundle between ROB commit, the
// architectural map and the rename stage.
interface arch_rat_retire_if #(
    parameter int unsigned ARCH_REGS   = arch_rat_retire_pkg::ARCH_REGS_DEF,
    parameter int unsigned PREG_W      = arch_rat_retire_pkg::PREG_W_DEF,
    parameter int unsigned RETIRE_W    = arch_rat_retire_pkg::RETIRE_W_DEF,
    parameter int unsigned RECOV_LANES = arch_rat_retire_pkg::RECOV_LANES_DEF
);
    localparam int unsigned AR_W  = $clog2(ARCH_REGS);
    localparam int unsigned BEATS = ARCH_REGS / RECOV_LANES;
    localparam int unsigned IDX_W = arch_rat_retire_pkg::idx_width(BEATS);

    logic                          arch_sstop;
    logic [RETIRE_W-1:0]           retire_valid;
    logic [RETIRE_W*AR_W-1:0]      retire_ar;
    logic [RETIRE_W*PREG_W-1:0]    retire_pr;
    logic [RETIRE_W-1:0]           free_valid;
    logic [RETIRE_W*PREG_W-1:0]    free_pr;
    logic                          recover_req;
    logic                          recover_busy;
    logic                          recover_valid;
    logic [IDX_W-1:0]              recover_idx;
    logic [RECOV_LANES*PREG_W-1:0] recover_data;
    logic                          recover_done;

    modport master (
        output arch_sstop, retire_valid, retire_ar, retire_pr, recover_req,
        input  free_valid, free_pr, recover_busy, recover_valid, recover_idx,
               recover_data, recover_done
    );

    modport slave (
        input  arch_sstop, retire_valid, retire_ar, retire_pr, recover_req,
        output free_valid, free_pr, recover_busy, recover_valid, recover_idx,
               recover_data, recover_done
    );

endinterface

// File: rtl/arch_rat_retire_map_resolve.sv
// Combinational resolution of one retire group: per-slot displaced register with
// intra-group bypass, and per-entry write enable/data with highest-slot priority.
module retire_map_resolve #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PREG_W    = 7,
    parameter int unsigned RETIRE_W  = 4,
    parameter int unsigned AR_W      = $clog2(ARCH_REGS)
) (
    input  logic [ARCH_REGS-1:0][PREG_W-1:0] map,
    input  logic [RETIRE_W-1:0]              valid,
    input  logic [RETIRE_W-1:0][AR_W-1:0]    ar,
    input  logic [RETIRE_W-1:0][PREG_W-1:0]  pr,
    output logic [RETIRE_W-1:0]              free_valid,
    output logic [RETIRE_W-1:0][PREG_W-1:0]  displaced,
    output logic [ARCH_REGS-1:0]             wr_en,
    output logic [ARCH_REGS-1:0][PREG_W-1:0] wr_data
);

    logic [RETIRE_W-1:0] eff;

    // Arch reg 0 is hard-wired, so those slots neither write nor free.
    always_comb begin
        eff = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            eff[i] = valid[i] && (ar[i] != '0);
        end
    end

    assign free_valid = eff;

    // Older slots in the same group override the table value seen by a younger slot.
    always_comb begin
        displaced = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            displaced[i] = map[ar[i]];
            for (int j = 0; j < i; j++) begin
                if (eff[j] && (ar[j] == ar[i])) begin
                    displaced[i] = pr[j];
                end
            end
        end
    end

    always_comb begin
        wr_en   = '0;
        wr_data = map;
        for (int e = 0; e < ARCH_REGS; e++) begin
            for (int j = 0; j < RETIRE_W; j++) begin
                if (eff[j] && (ar[j] == AR_W'(e))) begin
                    wr_en[e]   = 1'b1;
                    wr_data[e] = pr[j];
                end
            end
        end
    end

endmodule

// File: rtl/arch_rat_retire.sv
// Architectural register alias table: commits in-order retirements, returns displaced
// physical regs to the free list, and streams the committed map on recovery.
module arch_rat_retire
    import arch_rat_retire_pkg::*;
#(
    parameter int unsigned ARCH_REGS   = ARCH_REGS_DEF,
    parameter int unsigned PREG_W      = PREG_W_DEF,
    parameter int unsigned RETIRE_W    = RETIRE_W_DEF,
    parameter int unsigned RECOV_LANES = RECOV_LANES_DEF
) (
    input logic              clk,
    input logic              rst,
    arch_rat_retire_if.slave bus
);

    localparam int unsigned AR_W  = $clog2(ARCH_REGS);
    localparam int unsigned BEATS = ARCH_REGS / RECOV_LANES;
    localparam int unsigned IDX_W = idx_width(BEATS);

    logic [ARCH_REGS-1:0][PREG_W-1:0] map_q, map_d;
    logic [RETIRE_W-1:0]              free_valid_q, free_valid_d;
    logic [RETIRE_W-1:0][PREG_W-1:0]  free_pr_q, free_pr_d;
    rat_state_e                       state_q, state_d;
    logic [IDX_W-1:0]                 beat_q, beat_d;

    logic                             retire_en;
    logic [RETIRE_W-1:0]              res_free_valid;
    logic [RETIRE_W-1:0][PREG_W-1:0]  res_displaced;
    logic [ARCH_REGS-1:0]             res_wr_en;
    logic [ARCH_REGS-1:0][PREG_W-1:0] res_wr_data;
    logic [RETIRE_W-1:0][AR_W-1:0]    retire_ar;
    logic [RETIRE_W-1:0][PREG_W-1:0]  retire_pr;
    logic [AR_W-1:0]                  slice_base;
    logic                             copy_active;

    assign retire_ar = bus.retire_ar;
    assign retire_pr = bus.retire_pr;

    retire_map_resolve #(
        .ARCH_REGS (ARCH_REGS),
        .PREG_W    (PREG_W),
        .RETIRE_W  (RETIRE_W),
        .AR_W      (AR_W)
    ) u_resolve (
        .map        (map_q),
        .valid      (bus.retire_valid),
        .ar         (retire_ar),
        .pr         (retire_pr),
        .free_valid (res_free_valid),
        .displaced  (res_displaced),
        .wr_en      (res_wr_en),
        .wr_data    (res_wr_data)
    );

    // The ROB is flushed while copying, so retires only count in idle.
    assign retire_en = (state_q == StIdle) && !bus.arch_sstop;

    always_comb begin
        map_d        = map_q;
        free_valid_d = '0;
        free_pr_d    = free_pr_q;
        if (retire_en) begin
            free_valid_d = res_free_valid;
            free_pr_d    = res_displaced;
            for (int e = 0; e < ARCH_REGS; e++) begin
                if (res_wr_en[e]) begin
                    map_d[e] = res_wr_data[e];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        copy_active = 1'b0;
        bus.recover_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.recover_req) begin
                    state_d = StCopy;
                    beat_d  = '0;
                end
            end
            StCopy: begin
                copy_active = !bus.arch_sstop;
                if (beat_q == IDX_W'(BEATS - 1)) begin
                    bus.recover_done = !bus.arch_sstop;
                    state_d          = StIdle;
                    beat_d           = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                beat_d  = '0;
            end
        endcase
    end

    // Stall freezes everything; the table itself has no other hold path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < ARCH_REGS; j++) begin
                map_q[j] <= PREG_W'(j);
            end
            free_valid_q <= '0;
            free_pr_q    <= '0;
            state_q      <= StIdle;
            beat_q       <= '0;
        end else if (!bus.arch_sstop) begin
            map_q        <= map_d;
            free_valid_q <= free_valid_d;
            free_pr_q    <= free_pr_d;
            state_q      <= state_d;
            beat_q       <= beat_d;
        end
    end

    assign slice_base = AR_W'(beat_q) * AR_W'(RECOV_LANES);

    always_comb begin
        bus.recover_data = '0;
        if (copy_active) begin
            bus.recover_data = map_q[slice_base +: RECOV_LANES];
        end
    end

    assign bus.recover_busy  = (state_q != StIdle);
    assign bus.recover_valid = copy_active;
    assign bus.recover_idx   = beat_q;
    assign bus.free_valid    = free_valid_q;
    assign bus.free_pr       = free_pr_q;

endmodule
